// File: rtl/ristretto_prefetch_fetch_unit.sv
// Credit-based, in-order instruction fetch unit with response FIFO and redirect flushing.
// Optional hazard NOP injection is enabled by defining RISTRETTO_FU_NOP_INJECT_EN.
module ristretto_prefetch_fetch_unit #(
   parameter int unsigned          DataWidth      = 32,
   parameter int unsigned          AddrWidth      = 32,
   parameter int unsigned          FifoDepth      = 4,
   parameter int unsigned          MaxOutstanding = 2,
   parameter logic [AddrWidth-1:0] BootAddr       = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 fu_fetch_en_i,
   input  logic                 fu_redirect_i,
   input  logic [AddrWidth-1:0] fu_redirect_addr_i,
   output logic                 fu_instr_req_o,
   output logic [AddrWidth-1:0] fu_instr_addr_o,
   input  logic                 fu_instr_ready_i,
   input  logic                 fu_instr_valid_i,
   input  logic [DataWidth-1:0] fu_instr_rdata_i,
   output logic [DataWidth-1:0] fu_instr_o,
   output logic [AddrWidth-1:0] fu_instr_pc_o,
   output logic                 fu_new_instr_o,
   input  logic                 fu_instr_consume_i,
   output logic                 fu_stage_busy_o,
   output logic [1:0]           fu_penality_o,
   input  logic                 fu_trap_hazard_flag_i,
   input  logic                 fu_ctrl_hazard_flag_i
);

   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = $clog2(FifoDepth + 1);
   localparam logic [CntW:0]      DepthC = (CntW + 1)'(FifoDepth);
   localparam logic [CntW-1:0]    MaxC   = CntW'(MaxOutstanding);
   localparam logic [DataWidth-1:0] Nop  = DataWidth'(32'h0000_0013);

   typedef enum logic {StIdle, StReq} fu_state_e;

   fu_state_e            state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [AddrWidth-1:0] pc_q, pc_d;
   logic [CntW-1:0]      out_q, out_d;
   logic [CntW-1:0]      disc_q, disc_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]      infl_wr_q, infl_wr_d;
   logic [PtrW-1:0]      infl_rd_q, infl_rd_d;

   logic [DataWidth-1:0] fifo_data_q [FifoDepth];
   logic [AddrWidth-1:0] fifo_pc_q   [FifoDepth];
   // Addresses of accepted requests, in issue order, awaiting their response.
   logic [AddrWidth-1:0] infl_pc_q   [FifoDepth];

   logic                 accept, rsp, push, pop, fifo_empty, credit, launch;
   logic [AddrWidth-1:0] next_pc;
   logic [DataWidth-1:0] head_instr;

   assign fu_instr_req_o  = (state_q == StReq);
   assign fu_instr_addr_o = addr_q;
   assign fifo_empty      = (cnt_q == '0);
   assign accept          = fu_instr_req_o & fu_instr_ready_i;
   // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
   assign rsp             = fu_instr_valid_i & (out_q != '0);
   assign push            = rsp & (disc_q == '0) & ~fu_redirect_i;
   assign pop             = ~fifo_empty & fu_instr_consume_i & ~fu_redirect_i;
   assign next_pc         = fu_redirect_i ? fu_redirect_addr_i : pc_q;

   always_comb begin
      out_d     = out_q;
      disc_d    = disc_q;
      cnt_d     = cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      infl_wr_d = infl_wr_q;
      infl_rd_d = infl_rd_q;
      state_d   = state_q;
      addr_d    = addr_q;
      pc_d      = next_pc;
      launch    = 1'b0;

      if (accept && !rsp) begin
         out_d = out_q + CntW'(1);
      end else if (!accept && rsp) begin
         out_d = out_q - CntW'(1);
      end
      if (accept) infl_wr_d = infl_wr_q + PtrW'(1);
      if (rsp)    infl_rd_d = infl_rd_q + PtrW'(1);

      if (fu_redirect_i) begin
         // A still-unaccepted request will be issued later; its data must be dropped too.
         disc_d   = out_d + CntW'(fu_instr_req_o & ~fu_instr_ready_i);
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (rsp && disc_q != '0) disc_d = disc_q - CntW'(1);
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
         end else if (!push && pop) begin
            cnt_d = cnt_q - CntW'(1);
         end
      end

      // Credit is judged on next-cycle occupancy plus the request that would be raised.
      credit = (({1'b0, out_d} + {1'b0, cnt_d}) < DepthC) && (out_d < MaxC);

      unique case (state_q)
         StIdle: begin
            if (fu_fetch_en_i && credit && !fu_redirect_i) launch = 1'b1;
         end
         StReq: begin
            if (accept) begin
               launch = fu_fetch_en_i & credit;
               if (!launch) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (launch) begin
         state_d = StReq;
         addr_d  = next_pc;
         pc_d    = next_pc + AddrWidth'(4);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         addr_q    <= BootAddr;
         pc_q      <= BootAddr;
         out_q     <= '0;
         disc_q    <= '0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         infl_wr_q <= '0;
         infl_rd_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         pc_q      <= pc_d;
         out_q     <= out_d;
         disc_q    <= disc_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         infl_wr_q <= infl_wr_d;
         infl_rd_q <= infl_rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= fu_instr_rdata_i;
         fifo_pc_q[wr_ptr_q]   <= infl_pc_q[infl_rd_q];
      end
      if (accept) infl_pc_q[infl_wr_q] <= addr_q;
   end

   assign head_instr      = fifo_empty ? Nop : fifo_data_q[rd_ptr_q];
   assign fu_instr_pc_o   = fifo_empty ? pc_q : fifo_pc_q[rd_ptr_q];
   assign fu_new_instr_o  = ~fifo_empty;
   assign fu_stage_busy_o = fu_instr_req_o | (out_q != '0);

`ifdef RISTRETTO_FU_NOP_INJECT_EN
   assign fu_instr_o    = (fu_ctrl_hazard_flag_i | fu_trap_hazard_flag_i) ? Nop : head_instr;
   assign fu_penality_o = {fu_trap_hazard_flag_i, fu_ctrl_hazard_flag_i};
`else
   logic unused_hazard;
   assign unused_hazard = fu_ctrl_hazard_flag_i ^ fu_trap_hazard_flag_i;
   assign fu_instr_o    = head_instr;
   assign fu_penality_o = 2'b00;
`endif

endmodule

// File: tb/tb_ristretto_prefetch_fetch_unit.sv
// Bench for ristretto_prefetch_fetch_unit: directed vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_ristretto_prefetch_fetch_unit;
   localparam int unsigned Depth = 4;
   localparam int unsigned Max   = 2;
   localparam logic [31:0] Nop   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        fe, redir, rdy, vld, cons, ctrl, trap;
   logic [31:0] raddr, rdata;
   logic        req_o, new_o, busy_o;
   logic [31:0] addr_o, instr_o, pc_o;
   logic [1:0]  pen_o;

   always #5 clk = ~clk;

   ristretto_prefetch_fetch_unit dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .fu_fetch_en_i         (fe),
      .fu_redirect_i         (redir),
      .fu_redirect_addr_i    (raddr),
      .fu_instr_req_o        (req_o),
      .fu_instr_addr_o       (addr_o),
      .fu_instr_ready_i      (rdy),
      .fu_instr_valid_i      (vld),
      .fu_instr_rdata_i      (rdata),
      .fu_instr_o            (instr_o),
      .fu_instr_pc_o         (pc_o),
      .fu_new_instr_o        (new_o),
      .fu_instr_consume_i    (cons),
      .fu_stage_busy_o       (busy_o),
      .fu_penality_o         (pen_o),
      .fu_trap_hazard_flag_i (trap),
      .fu_ctrl_hazard_flag_i (ctrl)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] pc;
      bit          disc;
   } infl_t;
   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
   } ent_t;
   typedef struct {
      bit fe, rdy, vld; logic [31:0] rdata; bit cons, ctrl, trap;
      bit e_req; logic [31:0] e_addr; bit e_new; logic [31:0] e_instr, e_pc;
      bit e_busy; logic [1:0] e_pen;
   } vec_t;

   infl_t       infl_q[$];
   ent_t        fifo_q[$];
   logic [31:0] mem_q[$];
   bit          m_req, m_stale;
   logic [31:0] m_addr, m_pc;
   logic        s_req, s_new;
   logic [31:0] s_addr, s_pc;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; fe = 0; redir = 0; raddr = '0; rdy = 0; vld = 0; rdata = '0;
      cons = 0; ctrl = 0; trap = 0;
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(req_o), 32'd0);
      chk("rst_addr", addr_o, 32'd0);
      chk("rst_new", 32'(new_o), 32'd0);
      chk("rst_instr", instr_o, Nop);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_pen", 32'(pen_o), 32'd0);
      rst = 1'b0;
      infl_q.delete(); fifo_q.delete(); mem_q.delete();
      m_req = 0; m_stale = 0; m_addr = '0; m_pc = '0;
   endtask

   // One cycle against the reference model; mg lets the memory answer its oldest request.
   task automatic mcycle(input bit f, input bit r, input bit c, input bit rd,
                         input logic [31:0] ra, input bit hc, input bit ht, input bit mg);
      logic [31:0] exp_instr, tgt;
      bit          acc, rsp, credit;
      infl_t       e;
      @(negedge clk);
      fe = f; rdy = r; cons = c; redir = rd; raddr = ra; ctrl = hc; trap = ht;
      if (mg && mem_q.size() > 0) begin
         vld = 1'b1;
         rdata = memfn(mem_q.pop_front());
      end else begin
         vld = 1'b0;
         rdata = $urandom;
      end
      #1;
      s_req = req_o; s_addr = addr_o; s_new = new_o; s_pc = pc_o;
      chk("req", 32'(req_o), 32'(m_req));
      if (m_req) chk("addr", addr_o, m_addr);
      chk("new", 32'(new_o), 32'(fifo_q.size() > 0));
      exp_instr = (fifo_q.size() > 0) ? fifo_q[0].data : Nop;
`ifdef RISTRETTO_FU_NOP_INJECT_EN
      if (hc || ht) exp_instr = Nop;
      chk("pen", 32'(pen_o), 32'({ht, hc}));
`else
      chk("pen", 32'(pen_o), 32'd0);
`endif
      chk("instr", instr_o, exp_instr);
      if (fifo_q.size() > 0) chk("pc", pc_o, fifo_q[0].pc);
      chk("busy", 32'(busy_o), 32'(m_req || infl_q.size() > 0));
      @(posedge clk);
      acc = m_req && r;
      rsp = vld;
      if (rd) fifo_q.delete();
      else if (fifo_q.size() > 0 && c) void'(fifo_q.pop_front());
      if (rsp) begin
         e = infl_q.pop_front();
         if (!e.disc && !rd) fifo_q.push_back('{data: memfn(e.pc), pc: e.pc});
      end
      if (acc) begin
         infl_q.push_back('{pc: m_addr, disc: m_stale});
         mem_q.push_back(m_addr);
      end
      if (rd) foreach (infl_q[i]) infl_q[i].disc = 1'b1;
      tgt = rd ? ra : m_pc;
      credit = (infl_q.size() + fifo_q.size() < Depth) && (infl_q.size() < Max);
      if (m_req && !acc) begin
         if (rd) begin
            m_stale = 1'b1;
            m_pc = ra;
         end
      end else if (f && (m_req || !rd) && credit) begin
         m_req = 1'b1; m_addr = tgt; m_pc = tgt + 32'd4; m_stale = 1'b0;
      end else begin
         m_req = 1'b0; m_pc = tgt; m_stale = 1'b0;
      end
   endtask

   vec_t vecs[9];

   initial begin
      int  accepts;
      bit  found;
      vecs[0] = '{1,1,0,32'h0,1,0,0,  0,32'h0,0,Nop,32'h0,0,2'b00};
      vecs[1] = '{1,1,0,32'h0,1,0,0,  1,32'h0,0,Nop,32'h0,1,2'b00};
      vecs[2] = '{1,1,1,memfn(32'h0),1,0,0,  1,32'h4,0,Nop,32'h0,1,2'b00};
      vecs[3] = '{1,1,1,memfn(32'h4),1,0,0,  1,32'h8,1,memfn(32'h0),32'h0,1,2'b00};
`ifdef RISTRETTO_FU_NOP_INJECT_EN
      vecs[4] = '{1,1,1,memfn(32'h8),1,1,0,  1,32'hC,1,Nop,32'h4,1,2'b01};
      vecs[5] = '{0,1,1,memfn(32'hC),1,0,1,  1,32'h10,1,Nop,32'h8,1,2'b10};
`else
      vecs[4] = '{1,1,1,memfn(32'h8),1,1,0,  1,32'hC,1,memfn(32'h4),32'h4,1,2'b00};
      vecs[5] = '{0,1,1,memfn(32'hC),1,0,1,  1,32'h10,1,memfn(32'h8),32'h8,1,2'b00};
`endif
      vecs[6] = '{0,1,1,memfn(32'h10),1,0,0, 0,32'h0,1,memfn(32'hC),32'hC,1,2'b00};
      vecs[7] = '{0,1,0,32'h0,1,0,0,  0,32'h0,1,memfn(32'h10),32'h10,0,2'b00};
      vecs[8] = '{0,1,0,32'h0,1,0,0,  0,32'h0,0,Nop,32'h0,0,2'b00};

      rst = 1'b1;
      do_reset();

      // Streaming fetch from the vector table.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         fe = vecs[i].fe; rdy = vecs[i].rdy; vld = vecs[i].vld; rdata = vecs[i].rdata;
         cons = vecs[i].cons; ctrl = vecs[i].ctrl; trap = vecs[i].trap; redir = 0;
         #1;
         chk($sformatf("v%0d_req", i), 32'(req_o), 32'(vecs[i].e_req));
         if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), addr_o, vecs[i].e_addr);
         chk($sformatf("v%0d_new", i), 32'(new_o), 32'(vecs[i].e_new));
         chk($sformatf("v%0d_instr", i), instr_o, vecs[i].e_instr);
         if (vecs[i].e_new) chk($sformatf("v%0d_pc", i), pc_o, vecs[i].e_pc);
         chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
         chk($sformatf("v%0d_pen", i), 32'(pen_o), 32'(vecs[i].e_pen));
      end

      // Fill with consume low: exactly Depth accepts, then requests stop.
      do_reset();
      accepts = 0;
      for (int i = 0; i < 10; i++) begin
         mcycle(1, 1, 0, 0, '0, 0, 0, 1);
         if (s_req) accepts++;
      end
      chk("fill_accepts", 32'(accepts), 32'd4);
      chk("fill_req_off", 32'(s_req), 32'd0);
      chk("fill_full", 32'(s_new), 32'd1);
      for (int i = 0; i < 10; i++) mcycle(1, 1, 1, 0, '0, 0, 0, 1);

      // Redirect with two requests outstanding.
      do_reset();
      for (int i = 0; i < 3; i++) mcycle(1, 1, 1, 0, '0, 0, 0, 0);
      mcycle(1, 1, 1, 1, 32'h100, 0, 0, 0);
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         mcycle(1, 1, 0, 0, '0, 0, 0, 1);
         if (s_new) begin
            found = 1;
            chk("redir_first_pc", s_pc, 32'h100);
         end
      end
      if (!found) chk("redir_timeout", 32'd0, 32'd1);

      // Redirect while a request waits for ready: old address is still issued, then dropped.
      do_reset();
      mcycle(1, 0, 1, 0, '0, 0, 0, 1);
      mcycle(1, 0, 1, 1, 32'h200, 0, 0, 1);
      chk("pend_req", 32'(s_req), 32'd1);
      chk("pend_addr", s_addr, 32'h0);
      mcycle(1, 0, 1, 0, '0, 0, 0, 1);
      chk("pend_hold", s_addr, 32'h0);
      mcycle(1, 1, 1, 0, '0, 0, 0, 1);
      mcycle(1, 1, 0, 0, '0, 0, 0, 1);
      chk("pend_new_addr", s_addr, 32'h200);
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         mcycle(1, 1, 0, 0, '0, 0, 0, 1);
         if (s_new) begin
            found = 1;
            chk("pend_first_pc", s_pc, 32'h200);
         end
      end
      if (!found) chk("pend_timeout", 32'd0, 32'd1);

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         mcycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) < 3, $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 6);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
